// File: rtl/npc_dbg_pkg.sv
// rtl/npc_dbg_pkg.sv - shared types and constants for the commit monitor
package npc_dbg_pkg;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        HUNG   = 2'd2
    } cm_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } trace_entry_t;

endpackage

// File: rtl/commit_monitor_if.sv
// rtl/commit_monitor_if.sv - retire-stage to commit-monitor handshake
interface commit_monitor_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_invalid;

    modport master (output in_valid, output in_pc, output in_inst, output in_invalid,
                    input  in_ready);
    modport slave  (input  in_valid, input  in_pc, input  in_inst, input  in_invalid,
                    output in_ready);
endinterface

// File: rtl/commit_monitor_trace_ring.sv
// rtl/commit_monitor_trace_ring.sv - circular buffer of recent commits, newest-relative read
module trace_ring
    import npc_dbg_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  trace_entry_t               wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
    output trace_entry_t               rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    trace_entry_t      mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW:0]       count_q, count_d;
    logic [AW-1:0]     rd_slot;

    // Contents are never reset; count_q alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        count_d = count_q;
        if (wr_en_i) begin
            wptr_d = wptr_q + AW'(1);
            if (count_q != (AW+1)'(DEPTH)) begin
                count_d = count_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Index 0 is the slot just behind the write pointer; unwritten slots read as zero.
    assign rd_slot   = wptr_q - AW'(1) - rd_idx_i;
    assign rd_data_o = ({1'b0, rd_idx_i} < count_q) ? mem_q[rd_slot] : '0;
    assign count_o   = count_q;

endmodule

// File: rtl/commit_monitor.sv
// rtl/commit_monitor.sv - retire-stage monitor: debugger feed, halt detect, trace, watchdog
module commit_monitor
    import npc_dbg_pkg::*;
#(
    parameter int          TRACE_DEPTH = 16,
    parameter int          TIMEOUT     = 1048576,
    parameter logic [31:0] RESET_PC    = 32'h8000_0000
) (
    input  logic                            clk,
    input  logic                            reset,
    commit_monitor_if.slave                 up,
    output logic                            dbg_valid,
    output logic [31:0]                     dbg_pc,
    output logic [31:0]                     dbg_inst,
    output logic                            dbg_is_ebreak,
    output logic                            dbg_is_invalid,
    output logic                            halted,
    output logic                            hang,
    output logic [63:0]                     commit_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0]  trace_rd_idx,
    output logic [31:0]                     trace_rd_pc,
    output logic [31:0]                     trace_rd_inst,
    output logic [$clog2(TRACE_DEPTH):0]    trace_count
);
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

    cm_state_t     state_q, state_d;
    logic          ready_q, ready_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic          valid_q, valid_d;
    logic          ebreak_q, ebreak_d;
    logic          invalid_q, invalid_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   inst_q, inst_d;
    logic [63:0]   count_q, count_d;
    logic          hs;
    trace_entry_t  wr_entry;
    trace_entry_t  rd_entry;

    assign hs = up.in_valid & ready_q;

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        valid_d   = hs;
        invalid_d = hs & up.in_invalid;
        ebreak_d  = hs & ~up.in_invalid & (up.in_inst == EBREAK_INST);
        pc_d      = hs ? up.in_pc   : pc_q;
        inst_d    = hs ? up.in_inst : inst_q;
        count_d   = hs ? count_q + 64'd1 : count_q;
        case (state_q)
            RUN: begin
                // A handshake in the limit cycle takes priority over the timeout.
                if (hs) begin
                    wd_d = '0;
                    if (ebreak_d || invalid_d) begin
                        state_d = HALTED;
                    end
                end else if (wd_q == WD_LIMIT) begin
                    state_d = HUNG;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            default: ;
        endcase
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            ready_q   <= 1'b1;
            wd_q      <= '0;
            valid_q   <= 1'b0;
            ebreak_q  <= 1'b0;
            invalid_q <= 1'b0;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            wd_q      <= wd_d;
            valid_q   <= valid_d;
            ebreak_q  <= ebreak_d;
            invalid_q <= invalid_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            count_q   <= count_d;
        end
    end

    assign wr_entry.pc   = up.in_pc;
    assign wr_entry.inst = up.in_inst;

    trace_ring #(.DEPTH(TRACE_DEPTH)) u_ring (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en_i   (hs),
        .wr_data_i (wr_entry),
        .rd_idx_i  (trace_rd_idx),
        .rd_data_o (rd_entry),
        .count_o   (trace_count)
    );

    assign up.in_ready     = ready_q;
    assign dbg_valid       = valid_q;
    assign dbg_pc          = pc_q;
    assign dbg_inst        = inst_q;
    assign dbg_is_ebreak   = ebreak_q;
    assign dbg_is_invalid  = invalid_q;
    assign halted          = (state_q == HALTED);
    assign hang            = (state_q == HUNG);
    assign commit_count    = count_q;
    assign trace_rd_pc     = rd_entry.pc;
    assign trace_rd_inst   = rd_entry.inst;

endmodule

// File: tb/tb_commit_monitor.sv
// tb/tb_commit_monitor.sv - randomized self-checking bench for commit_monitor
module tb_commit_monitor;
    localparam int          DEPTH   = 16;
    localparam int          TIMEOUT = 8;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dbg_valid, dbg_is_ebreak, dbg_is_invalid, halted, hang;
    logic [31:0] dbg_pc, dbg_inst, trace_rd_pc, trace_rd_inst;
    logic [63:0] commit_count;
    logic [3:0]  trace_rd_idx = '0;
    logic [4:0]  trace_count;

    int n_cmp = 0;
    int n_bad = 0;

    commit_monitor_if bus ();

    commit_monitor #(.TRACE_DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .reset(reset), .up(bus),
        .dbg_valid(dbg_valid), .dbg_pc(dbg_pc), .dbg_inst(dbg_inst),
        .dbg_is_ebreak(dbg_is_ebreak), .dbg_is_invalid(dbg_is_invalid),
        .halted(halted), .hang(hang), .commit_count(commit_count),
        .trace_rd_idx(trace_rd_idx), .trace_rd_pc(trace_rd_pc),
        .trace_rd_inst(trace_rd_inst), .trace_count(trace_count)
    );

    always #5 clk = ~clk;

    // Reference model: history as a newest-first queue, idle-cycle count, sticky flags.
    bit              m_halted, m_hang, m_valid, m_eb, m_inv;
    int              m_idle;
    longint unsigned m_count;
    logic [31:0]     m_pc, m_inst;
    logic [31:0]     q_pc[$];
    logic [31:0]     q_inst[$];

    function automatic void model_reset();
        m_halted = 0; m_hang = 0; m_valid = 0; m_eb = 0; m_inv = 0;
        m_idle = 0; m_count = 0; m_pc = 32'h8000_0000; m_inst = 0;
        q_pc.delete(); q_inst.delete();
    endfunction

    function automatic void model_edge(bit v, logic [31:0] pc, logic [31:0] inst, bit inv);
        bit hs;
        hs = v && !m_halted && !m_hang;
        m_valid = hs;
        m_eb    = hs && (inst == EBREAK) && !inv;
        m_inv   = hs && inv;
        if (hs) begin
            m_count++;
            m_pc = pc; m_inst = inst;
            q_pc.push_front(pc); q_inst.push_front(inst);
            if (q_pc.size() > DEPTH) begin
                void'(q_pc.pop_back()); void'(q_inst.pop_back());
            end
            m_idle = 0;
            if (m_eb || m_inv) m_halted = 1;
        end else if (!m_halted && !m_hang) begin
            m_idle++;
            if (m_idle == TIMEOUT) m_hang = 1;
        end
    endfunction

    function automatic logic [31:0] exp_trace_pc(int idx);
        return (idx < q_pc.size()) ? q_pc[idx] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_trace_inst(int idx);
        return (idx < q_inst.size()) ? q_inst[idx] : 32'h0;
    endfunction

    function automatic logic [31:0] plain_inst();
        logic [31:0] w;
        w = $urandom;
        if (w == EBREAK) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.in_invalid = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] inst, input bit inv);
        bus.in_valid = v; bus.in_pc = pc; bus.in_inst = inst; bus.in_invalid = inv;
        @(posedge clk);
        model_edge(v, pc, inst, inv);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (dbg_pc !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_dbg_pc got=%h exp=%h", dbg_pc, 32'h8000_0000); end
        n_cmp++; if (dbg_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dbg_valid got=%b exp=0", dbg_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        n_cmp++; if (commit_count !== 64'd0) begin n_bad++; $display("FAIL reset_commit_count got=%0d exp=0", commit_count); end
        n_cmp++; if (trace_count !== 5'd0) begin n_bad++; $display("FAIL reset_trace_count got=%0d exp=0", trace_count); end
        n_cmp++; if ({halted, hang, dbg_inst} !== 34'd0) begin n_bad++; $display("FAIL reset_flags got=%b%b inst=%h exp=0", halted, hang, dbg_inst); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h8000_0000 + 32'(4 * i), plain_inst(), 1'b0);
            n_cmp++; if (dbg_valid !== 1'b1 || dbg_pc !== m_pc || dbg_inst !== m_inst) begin
                n_bad++; $display("FAIL b2b_commit%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", i, dbg_valid, dbg_pc, dbg_inst, m_pc, m_inst);
            end
        end
        cycle(1'b0, '0, '0, 1'b0);
        n_cmp++; if (dbg_valid !== 1'b0 || dbg_pc !== 32'h8000_000C) begin n_bad++; $display("FAIL b2b_idle got v=%b pc=%h exp v=0 pc=8000000c", dbg_valid, dbg_pc); end
        n_cmp++; if (commit_count !== 64'd4) begin n_bad++; $display("FAIL b2b_count got=%0d exp=4", commit_count); end
        trace_rd_idx = 4'd0; #1;
        n_cmp++; if (trace_rd_pc !== 32'h8000_000C) begin n_bad++; $display("FAIL b2b_idx0 got=%h exp=8000000c", trace_rd_pc); end
        trace_rd_idx = 4'd3; #1;
        n_cmp++; if (trace_rd_pc !== 32'h8000_0000) begin n_bad++; $display("FAIL b2b_idx3 got=%h exp=80000000", trace_rd_pc); end
        trace_rd_idx = 4'd4; #1;
        n_cmp++; if (trace_rd_pc !== 32'h0 || trace_rd_inst !== 32'h0) begin n_bad++; $display("FAIL b2b_idx4 got=%h/%h exp=0/0", trace_rd_pc, trace_rd_inst); end
    endtask

    task automatic test_ebreak();
        do_reset();
        cycle(1'b1, 32'h8000_0040, plain_inst(), 1'b0);
        cycle(1'b1, 32'h8000_0044, EBREAK, 1'b0);
        n_cmp++; if ({dbg_valid, dbg_is_ebreak, dbg_is_invalid, halted, bus.in_ready} !== 5'b11010) begin
            n_bad++; $display("FAIL ebreak_flags got v/eb/inv/halt/rdy=%b%b%b%b%b exp=11010", dbg_valid, dbg_is_ebreak, dbg_is_invalid, halted, bus.in_ready);
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h8000_0048, plain_inst(), 1'b0);
        n_cmp++; if (commit_count !== 64'd2 || dbg_valid !== 1'b0 || dbg_pc !== 32'h8000_0044) begin
            n_bad++; $display("FAIL ebreak_blocked got cnt=%0d v=%b pc=%h exp cnt=2 v=0 pc=80000044", commit_count, dbg_valid, dbg_pc);
        end
        n_cmp++; if (halted !== 1'b1 || hang !== 1'b0) begin n_bad++; $display("FAIL ebreak_sticky got halt=%b hang=%b exp 1/0", halted, hang); end
    endtask

    task automatic test_invalid();
        do_reset();
        cycle(1'b1, 32'h8000_0100, EBREAK, 1'b1);
        n_cmp++; if ({dbg_valid, dbg_is_invalid, dbg_is_ebreak, halted} !== 4'b1101) begin
            n_bad++; $display("FAIL invalid_priority got v/inv/eb/halt=%b%b%b%b exp=1101", dbg_valid, dbg_is_invalid, dbg_is_ebreak, halted);
        end
        trace_rd_idx = 4'd0; #1;
        n_cmp++; if (trace_rd_pc !== 32'h8000_0100 || trace_count !== 5'd1) begin
            n_bad++; $display("FAIL invalid_traced got pc=%h cnt=%0d exp 80000100/1", trace_rd_pc, trace_count);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b0, '0, '0, 1'b0);
        n_cmp++; if (hang !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL wd_before_limit got hang=%b rdy=%b exp 0/1", hang, bus.in_ready); end
        cycle(1'b0, '0, '0, 1'b0);
        n_cmp++; if (hang !== 1'b1 || bus.in_ready !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL wd_expire got hang=%b rdy=%b halt=%b exp 1/0/0", hang, bus.in_ready, halted); end
        cycle(1'b1, 32'h1234, plain_inst(), 1'b0);
        n_cmp++; if (commit_count !== 64'd0 || dbg_valid !== 1'b0) begin n_bad++; $display("FAIL wd_hung_blocks got cnt=%0d v=%b exp 0/0", commit_count, dbg_valid); end
    endtask

    task automatic test_watchdog_limit();
        do_reset();
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b1, 32'h8000_0200, plain_inst(), 1'b0);
        n_cmp++; if (hang !== 1'b0 || dbg_valid !== 1'b1 || commit_count !== 64'd1) begin
            n_bad++; $display("FAIL wd_limit_commit got hang=%b v=%b cnt=%0d exp 0/1/1", hang, dbg_valid, commit_count);
        end
        for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b0, '0, '0, 1'b0);
        n_cmp++; if (hang !== 1'b0) begin n_bad++; $display("FAIL wd_restart_early got hang=%b exp 0", hang); end
        cycle(1'b0, '0, '0, 1'b0);
        n_cmp++; if (hang !== 1'b1) begin n_bad++; $display("FAIL wd_restart_expire got hang=%b exp 1", hang); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'h0000_1000 + 32'(4 * i), plain_inst(), 1'b0);
        n_cmp++; if (trace_count !== 5'd16 || commit_count !== 64'd20) begin
            n_bad++; $display("FAIL wrap_counts got tc=%0d cc=%0d exp 16/20", trace_count, commit_count);
        end
        trace_rd_idx = 4'd15; #1;
        n_cmp++; if (trace_rd_pc !== 32'h0000_1010) begin n_bad++; $display("FAIL wrap_idx15 got=%h exp=00001010", trace_rd_pc); end
        for (int i = 0; i < DEPTH; i++) begin
            trace_rd_idx = 4'(i); #1;
            n_cmp++; if (trace_rd_pc !== exp_trace_pc(i) || trace_rd_inst !== exp_trace_inst(i)) begin
                n_bad++; $display("FAIL wrap_entry%0d got=%h/%h exp=%h/%h", i, trace_rd_pc, trace_rd_inst, exp_trace_pc(i), exp_trace_inst(i));
            end
        end
        // Assert reset away from the clock edge mid-burst.
        bus.in_valid = 1'b1; bus.in_pc = 32'hDEAD_0000; bus.in_inst = plain_inst(); bus.in_invalid = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_cmp++; if ({dbg_valid, dbg_is_ebreak, dbg_is_invalid, halted, hang} !== 5'd0 || dbg_pc !== 32'h8000_0000 ||
                     dbg_inst !== 32'h0 || commit_count !== 64'd0 || trace_count !== 5'd0) begin
            n_bad++; $display("FAIL async_reset got v=%b pc=%h inst=%h cc=%0d tc=%0d exp reset values", dbg_valid, dbg_pc, dbg_inst, commit_count, trace_count);
        end
        @(posedge clk); #1;
        n_cmp++; if (dbg_valid !== 1'b0 || commit_count !== 64'd0) begin n_bad++; $display("FAIL reset_drops_hs got v=%b cc=%0d exp 0/0", dbg_valid, commit_count); end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        cycle(1'b0, '0, '0, 1'b0);
        n_cmp++; if (dbg_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset got v=%b rdy=%b exp 0/1", dbg_valid, bus.in_ready); end
    endtask

    task automatic test_random();
        int idx;
        logic [31:0] inst;
        bit v, inv;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (m_halted || m_hang) do_reset();
            v    = ($urandom_range(0, 3) != 0);
            inst = ($urandom_range(0, 39) == 0) ? EBREAK : plain_inst();
            inv  = ($urandom_range(0, 49) == 0);
            cycle(v, $urandom, inst, inv);
            idx = $urandom_range(0, DEPTH - 1);
            trace_rd_idx = 4'(idx); #1;
            n_cmp++; if (dbg_valid !== m_valid || dbg_is_ebreak !== m_eb || dbg_is_invalid !== m_inv ||
                         dbg_pc !== m_pc || dbg_inst !== m_inst) begin
                n_bad++; $display("FAIL rand_dbg@%0d got v/eb/inv=%b%b%b pc=%h inst=%h exp %b%b%b pc=%h inst=%h",
                                  n, dbg_valid, dbg_is_ebreak, dbg_is_invalid, dbg_pc, dbg_inst, m_valid, m_eb, m_inv, m_pc, m_inst);
            end
            n_cmp++; if (halted !== m_halted || hang !== m_hang || bus.in_ready !== !(m_halted || m_hang) ||
                         commit_count !== m_count || trace_count !== 5'(q_pc.size())) begin
                n_bad++; $display("FAIL rand_state@%0d got h/g/r=%b%b%b cc=%0d tc=%0d exp %b%b%b cc=%0d tc=%0d",
                                  n, halted, hang, bus.in_ready, commit_count, trace_count, m_halted, m_hang, !(m_halted || m_hang), m_count, q_pc.size());
            end
            n_cmp++; if (trace_rd_pc !== exp_trace_pc(idx) || trace_rd_inst !== exp_trace_inst(idx)) begin
                n_bad++; $display("FAIL rand_trace@%0d idx=%0d got=%h/%h exp=%h/%h", n, idx, trace_rd_pc, trace_rd_inst, exp_trace_pc(idx), exp_trace_inst(idx));
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_ebreak();
        test_invalid();
        test_watchdog();
        test_watchdog_limit();
        test_wrap_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
